// File: rtl/tone_scheduler_if.sv
// Request/grant and tone-datapath signals shared by the melody sequencer,
// the keypad beep source and the tone scheduler.
interface tone_scheduler_if;
   logic        mel_req;
   logic [11:0] mel_note;
   logic [3:0]  mel_len;
   logic        mel_ack;
   logic        key_req;
   logic [11:0] key_note;
   logic        key_ack;
   logic [11:0] note;
   logic [13:0] origin;
   logic        busy;
   logic        src;
   logic        beat;

   // Requester side: raises requests, observes grants and the tone outputs.
   modport master (
      output mel_req, mel_note, mel_len, key_req, key_note,
      input  mel_ack, key_ack, note, origin, busy, src, beat
   );

   // Scheduler side.
   modport slave (
      input  mel_req, mel_note, mel_len, key_req, key_note,
      output mel_ack, key_ack, note, origin, busy, src, beat
   );
endinterface

// File: rtl/tone_scheduler.sv
// Tone scheduler: arbitrates the speaker tone datapath between the melody
// sequencer and the keypad beep, holds each granted note for a whole number
// of beats, then rests for an articulation gap before the next grant.
module tone_scheduler #(
   parameter int unsigned BEAT_DIV   = 1500000,
   parameter int unsigned BEEP_BEATS = 2,
   parameter int unsigned GAP_CYCLES = 60000
) (
   input  logic            clk_6MHz,
   input  logic            rst,
   tone_scheduler_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PLAY = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   localparam logic [20:0] BEAT_LAST = 21'(BEAT_DIV - 32'd1);
   localparam bit          GAP_EN    = (GAP_CYCLES != 32'd0);
   localparam logic [20:0] GAP_LAST  = GAP_EN ? 21'(GAP_CYCLES - 32'd1) : 21'd0;
   localparam logic [3:0]  BEEP_LEN  = 4'(BEEP_BEATS);
   localparam logic [13:0] SILENT    = 14'd16383;

   // Divider preload for a {high,med,low} note code; unknown codes are silent.
   function automatic logic [13:0] origin_lookup(input logic [11:0] code);
      logic [13:0] val;
      case (code)
         12'h003: val = 14'd7281;
         12'h005: val = 14'd8730;
         12'h006: val = 14'd9565;
         12'h007: val = 14'd10310;
         12'h010: val = 14'd10647;
         12'h020: val = 14'd11272;
         12'h030: val = 14'd11831;
         12'h050: val = 14'd12556;
         12'h060: val = 14'd12974;
         12'h100: val = 14'd13516;
         default: val = SILENT;
      endcase
      return val;
   endfunction

   state_t      r_state;
   logic [20:0] r_beat_cnt;
   logic [20:0] r_gap_cnt;
   logic [3:0]  r_remaining;
   logic [11:0] r_note;
   logic [13:0] r_origin;
   logic        r_mel_ack;
   logic        r_key_ack;
   logic        r_beat;
   logic        r_busy;
   logic        r_src;

   state_t      w_state_nxt;
   logic [20:0] w_beat_cnt_nxt;
   logic [20:0] w_gap_cnt_nxt;
   logic [3:0]  w_remaining_nxt;
   logic [11:0] w_note_nxt;
   logic [13:0] w_origin_nxt;
   logic        w_mel_ack_nxt;
   logic        w_key_ack_nxt;
   logic        w_beat_nxt;
   logic        w_busy_nxt;
   logic        w_src_nxt;

   logic        w_grant_key;
   logic        w_grant_mel;
   logic [3:0]  w_mel_beats;

   // On contention the source that did not own the last grant wins.
   assign w_grant_key = bus.key_req & (~bus.mel_req | ~r_src);
   assign w_grant_mel = bus.mel_req & ~w_grant_key;
   assign w_mel_beats = (bus.mel_len == 4'd0) ? 4'd1 : bus.mel_len;
   assign w_busy_nxt  = (w_state_nxt != ST_IDLE);

   // Next-state and next-output logic for the IDLE/PLAY/GAP sequencer.
   always_comb begin
      w_state_nxt     = r_state;
      w_beat_cnt_nxt  = r_beat_cnt;
      w_gap_cnt_nxt   = r_gap_cnt;
      w_remaining_nxt = r_remaining;
      w_note_nxt      = r_note;
      w_origin_nxt    = r_origin;
      w_mel_ack_nxt   = 1'b0;
      w_key_ack_nxt   = 1'b0;
      w_beat_nxt      = 1'b0;
      w_src_nxt       = r_src;

      case (r_state)
         ST_IDLE: begin
            if (w_grant_key) begin
               w_state_nxt     = ST_PLAY;
               w_key_ack_nxt   = 1'b1;
               w_note_nxt      = bus.key_note;
               w_origin_nxt    = origin_lookup(bus.key_note);
               w_remaining_nxt = BEEP_LEN;
               w_src_nxt       = 1'b1;
               w_beat_cnt_nxt  = 21'd0;
               w_gap_cnt_nxt   = 21'd0;
            end else if (w_grant_mel) begin
               w_state_nxt     = ST_PLAY;
               w_mel_ack_nxt   = 1'b1;
               w_note_nxt      = bus.mel_note;
               w_origin_nxt    = origin_lookup(bus.mel_note);
               w_remaining_nxt = w_mel_beats;
               w_src_nxt       = 1'b0;
               w_beat_cnt_nxt  = 21'd0;
               w_gap_cnt_nxt   = 21'd0;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end

         ST_PLAY: begin
            if (r_beat_cnt == BEAT_LAST) begin
               w_beat_nxt      = 1'b1;
               w_beat_cnt_nxt  = 21'd0;
               w_remaining_nxt = r_remaining - 4'd1;
               // A corrupted zero count also ends the note rather than wrapping.
               if (r_remaining <= 4'd1) begin
                  w_note_nxt      = 12'd0;
                  w_origin_nxt    = SILENT;
                  w_remaining_nxt = 4'd0;
                  w_gap_cnt_nxt   = 21'd0;
                  if (GAP_EN) begin
                     w_state_nxt = ST_GAP;
                  end else begin
                     w_state_nxt = ST_IDLE;
                  end
               end else begin
                  w_state_nxt = ST_PLAY;
               end
            end else begin
               w_beat_cnt_nxt = r_beat_cnt + 21'd1;
            end
         end

         ST_GAP: begin
            w_note_nxt   = 12'd0;
            w_origin_nxt = SILENT;
            if (r_gap_cnt >= GAP_LAST) begin
               w_state_nxt   = ST_IDLE;
               w_gap_cnt_nxt = 21'd0;
            end else begin
               w_gap_cnt_nxt = r_gap_cnt + 21'd1;
            end
         end

         default: begin
            w_state_nxt     = ST_IDLE;
            w_note_nxt      = 12'd0;
            w_origin_nxt    = SILENT;
            w_beat_cnt_nxt  = 21'd0;
            w_gap_cnt_nxt   = 21'd0;
            w_remaining_nxt = 4'd0;
         end
      endcase
   end

   // State register; reset forces IDLE immediately.
   always_ff @(posedge clk_6MHz or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Counters and registered outputs; reset silences the speaker at once.
   always_ff @(posedge clk_6MHz or posedge rst) begin
      if (rst) begin
         r_beat_cnt  <= 21'd0;
         r_gap_cnt   <= 21'd0;
         r_remaining <= 4'd0;
         r_note      <= 12'd0;
         r_origin    <= SILENT;
         r_mel_ack   <= 1'b0;
         r_key_ack   <= 1'b0;
         r_beat      <= 1'b0;
         r_busy      <= 1'b0;
         r_src       <= 1'b0;
      end else begin
         r_beat_cnt  <= w_beat_cnt_nxt;
         r_gap_cnt   <= w_gap_cnt_nxt;
         r_remaining <= w_remaining_nxt;
         r_note      <= w_note_nxt;
         r_origin    <= w_origin_nxt;
         r_mel_ack   <= w_mel_ack_nxt;
         r_key_ack   <= w_key_ack_nxt;
         r_beat      <= w_beat_nxt;
         r_busy      <= w_busy_nxt;
         r_src       <= w_src_nxt;
      end
   end

   assign bus.note    = r_note;
   assign bus.origin  = r_origin;
   assign bus.mel_ack = r_mel_ack;
   assign bus.key_ack = r_key_ack;
   assign bus.beat    = r_beat;
   assign bus.busy    = r_busy;
   assign bus.src     = r_src;

endmodule
